// File: rtl/hazard_ctrl_mc.sv
// Hazard/pipeline controller for the 5-stage RV32 core: forwarding, load-use,
// branch flush, fixed-latency multicycle execute, memory wait states and a stall counter.
module hazard_ctrl_mc #(
    parameter int REG_AW      = 5,
    parameter int MC_LAT      = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [1:0]        ResultSrcE,
    input  logic              PCSrcE,
    input  logic              McStartE,
    input  logic              MemReqM,
    input  logic              MemReadyM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              FlushW,
    output logic              McBusy,
    output logic              McDoneE,
    output logic              MemErr,
    output logic [CNT_W-1:0]  PerfStallCnt
);

    localparam int MCW  = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
    localparam int MEMW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [MCW-1:0]  MC_INIT   = MCW'((MC_LAT > 1) ? (MC_LAT - 2) : 0);
    localparam logic [MEMW-1:0] MEM_LIMIT = MEMW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MC_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            r_ret_state;
    state_t            w_next_state;
    state_t            w_eff_state;
    logic [MCW-1:0]    r_mc_cnt;
    logic [MEMW-1:0]   r_mem_cnt;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_perf_cnt;
    logic              w_mem_stall;
    logic              w_lw_stall;
    logic              w_mc_load;
    logic              w_mc_dec;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              regwrite_m,
        input logic [REG_AW-1:0] rd_m,
        input logic              regwrite_w,
        input logic [REG_AW-1:0] rd_w
    );
        if (regwrite_m && (rd_m != '0) && (rd_m == rs))
            return 2'b10;
        else if (regwrite_w && (rd_w != '0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_fwd_a     = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    assign w_fwd_b     = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
    assign w_mem_stall = MemReqM && !MemReadyM;
    assign w_lw_stall  = (ResultSrcE == 2'b01) && (RdE != '0) &&
                         ((Rs1D == RdE) || (Rs2D == RdE));
    // A memory wait behaves like the state it interrupted once memory is ready.
    assign w_eff_state = (r_state == ST_MEM_WAIT) ? r_ret_state : r_state;

    always_comb begin
        w_next_state = r_state;
        w_mc_load    = 1'b0;
        w_mc_dec     = 1'b0;
        ForwardAE    = 2'b00;
        ForwardBE    = 2'b00;
        StallF       = 1'b0;
        StallD       = 1'b0;
        StallE       = 1'b0;
        StallM       = 1'b0;
        FlushD       = 1'b0;
        FlushE       = 1'b0;
        FlushM       = 1'b0;
        FlushW       = 1'b0;
        McBusy       = 1'b0;
        McDoneE      = 1'b0;
        if (reset) begin
            w_next_state = ST_RUN;
            FlushD       = 1'b1;
            FlushE       = 1'b1;
            FlushM       = 1'b1;
            FlushW       = 1'b1;
        end else begin
            ForwardAE = w_fwd_a;
            ForwardBE = w_fwd_b;
            if (w_mem_stall) begin
                w_next_state = ST_MEM_WAIT;
                StallF       = 1'b1;
                StallD       = 1'b1;
                StallE       = 1'b1;
                StallM       = 1'b1;
                FlushW       = 1'b1;
                McBusy       = (w_eff_state == ST_MC_WAIT);
            end else begin
                case (w_eff_state)
                    ST_MC_WAIT: begin
                        McBusy = 1'b1;
                        if (r_mc_cnt == '0) begin
                            McDoneE      = 1'b1;
                            w_next_state = ST_RUN;
                        end else begin
                            w_next_state = ST_MC_WAIT;
                            w_mc_dec     = 1'b1;
                            StallF       = 1'b1;
                            StallD       = 1'b1;
                            StallE       = 1'b1;
                            FlushM       = 1'b1;
                        end
                    end
                    default: begin
                        w_next_state = ST_RUN;
                        if (McStartE) begin
                            // Multicycle ops never redirect, so PCSrcE is ignored here.
                            if (MC_LAT == 1) begin
                                McDoneE = 1'b1;
                                StallF  = w_lw_stall;
                                StallD  = w_lw_stall;
                                FlushE  = w_lw_stall;
                            end else begin
                                w_next_state = ST_MC_WAIT;
                                w_mc_load    = 1'b1;
                                StallF       = 1'b1;
                                StallD       = 1'b1;
                                StallE       = 1'b1;
                                FlushM       = 1'b1;
                            end
                        end else begin
                            StallF = w_lw_stall;
                            StallD = w_lw_stall && !PCSrcE;
                            FlushD = PCSrcE;
                            FlushE = w_lw_stall || PCSrcE;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_ret_state <= ST_RUN;
            r_mc_cnt    <= '0;
            r_mem_cnt   <= '0;
            r_mem_err   <= 1'b0;
            r_perf_cnt  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_mem_stall && (r_state != ST_MEM_WAIT))
                r_ret_state <= r_state;
            if (w_mc_load)
                r_mc_cnt <= MC_INIT;
            else if (w_mc_dec)
                r_mc_cnt <= r_mc_cnt - 1'b1;
            if (w_mem_stall) begin
                if (r_mem_cnt != MEM_LIMIT)
                    r_mem_cnt <= r_mem_cnt + 1'b1;
                if (r_mem_cnt == MEM_LIMIT - 1'b1)
                    r_mem_err <= 1'b1;
            end else begin
                r_mem_cnt <= '0;
            end
            if (StallF && (r_perf_cnt != {CNT_W{1'b1}}))
                r_perf_cnt <= r_perf_cnt + 1'b1;
        end
    end

    assign MemErr       = r_mem_err;
    assign PerfStallCnt = r_perf_cnt;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: vector table for forwarding/load-use/branch,
// hand-written sequences for multicycle, memory wait, timeout, reset abort and saturation.
module tb_hazard_ctrl_mc;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, McStartE, MemReqM, MemReadyM;

    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushM, FlushW;
    logic       McBusy, McDoneE, MemErr;
    logic [3:0] PerfStallCnt;

    logic [1:0] u1_ForwardAE, u1_ForwardBE;
    logic       u1_StallF, u1_StallD, u1_StallE, u1_StallM;
    logic       u1_FlushD, u1_FlushE, u1_FlushM, u1_FlushW;
    logic       u1_McBusy, u1_McDoneE, u1_MemErr;
    logic [3:0] u1_PerfStallCnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl_mc #(.REG_AW(5), .MC_LAT(4), .MEM_TIMEOUT(8), .CNT_W(4)) u_dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE),
        .PCSrcE(PCSrcE), .McStartE(McStartE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .McBusy(McBusy), .McDoneE(McDoneE), .MemErr(MemErr), .PerfStallCnt(PerfStallCnt)
    );

    hazard_ctrl_mc #(.REG_AW(5), .MC_LAT(1), .MEM_TIMEOUT(8), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE),
        .PCSrcE(PCSrcE), .McStartE(McStartE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(u1_ForwardAE), .ForwardBE(u1_ForwardBE),
        .StallF(u1_StallF), .StallD(u1_StallD), .StallE(u1_StallE), .StallM(u1_StallM),
        .FlushD(u1_FlushD), .FlushE(u1_FlushE), .FlushM(u1_FlushM), .FlushW(u1_FlushW),
        .McBusy(u1_McBusy), .McDoneE(u1_McDoneE), .MemErr(u1_MemErr), .PerfStallCnt(u1_PerfStallCnt)
    );

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       regwm, regww;
        logic [1:0] rsrc;
        logic       pcs;
        logic [1:0] fa, fb;
        logic       sf, sd, fd, fe;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(
        input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
        input logic regwm, regww, input logic [1:0] rsrc, input logic pcs,
        input logic [1:0] fa, fb, input logic sf, sd, fd, fe);
        vec_t v;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e; v.rde = rde;
        v.rdm = rdm; v.rdw = rdw; v.regwm = regwm; v.regww = regww; v.rsrc = rsrc;
        v.pcs = pcs; v.fa = fa; v.fb = fb; v.sf = sf; v.sd = sd; v.fd = fd; v.fe = fe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00;
        PCSrcE = 0; McStartE = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    initial begin
        //         rs1d rs2d rs1e rs2e rde rdm rdw wm ww rsrc   pcs  fa     fb     sf sd fd fe
        vecs[0] = mk(0, 0,   5,   0,   0,  5,  5,  1, 1, 2'b00, 0, 2'b10, 2'b00, 0, 0, 0, 0);
        vecs[1] = mk(0, 0,   5,   0,   0,  5,  5,  0, 1, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 0);
        vecs[2] = mk(0, 0,   0,   0,   0,  0,  0,  1, 1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        vecs[3] = mk(0, 0,   9,   7,   0,  9,  7,  1, 1, 2'b00, 0, 2'b10, 2'b01, 0, 0, 0, 0);
        vecs[4] = mk(0, 3,   0,   0,   3,  0,  0,  0, 0, 2'b01, 0, 2'b00, 2'b00, 1, 1, 0, 1);
        vecs[5] = mk(0, 0,   0,   0,   0,  0,  0,  0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 0, 1, 1);
        vecs[6] = mk(3, 0,   0,   0,   3,  0,  0,  0, 0, 2'b01, 1, 2'b00, 2'b00, 1, 0, 1, 1);
        vecs[7] = mk(0, 0,   0,   0,   0,  0,  0,  0, 0, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        vecs[8] = mk(3, 0,   0,   0,   3,  0,  0,  0, 0, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0, 0);

        // reset: forwarding condition present but suppressed
        reset = 1'b1;
        idle();
        RegWriteM = 1; RdM = 5; Rs1E = 5;
        samp();
        chk("rst_fwdA", ForwardAE, 2'b00);
        chk("rst_stalls", {StallF, StallD, StallE, StallM}, 4'b0000);
        chk("rst_flushes", {FlushD, FlushE, FlushM, FlushW}, 4'b1111);
        chk("rst_mc", {McBusy, McDoneE}, 2'b00);
        chk("rst_err_cnt", {MemErr, PerfStallCnt}, 5'd0);
        next_cyc();
        reset = 1'b0;
        idle();
        samp();
        chk("idle_all", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW}, 8'd0);
        next_cyc();

        for (int i = 0; i < 9; i++) begin
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e;
            Rs2E = vecs[i].rs2e; RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
            RegWriteM = vecs[i].regwm; RegWriteW = vecs[i].regww;
            ResultSrcE = vecs[i].rsrc; PCSrcE = vecs[i].pcs;
            samp();
            chk($sformatf("v%0d_fwdA", i), ForwardAE, vecs[i].fa);
            chk($sformatf("v%0d_fwdB", i), ForwardBE, vecs[i].fb);
            chk($sformatf("v%0d_stallF", i), StallF, vecs[i].sf);
            chk($sformatf("v%0d_stallD", i), StallD, vecs[i].sd);
            chk($sformatf("v%0d_flushD", i), FlushD, vecs[i].fd);
            chk($sformatf("v%0d_flushE", i), FlushE, vecs[i].fe);
            chk($sformatf("v%0d_EM", i), {StallE, StallM, FlushM, FlushW}, 4'b0000);
            next_cyc();
        end
        idle();
        samp();
        chk("perf_after_table", PerfStallCnt, 4'd2);

        // multicycle, MC_LAT=4 (u_dut) and MC_LAT=1 (u_dut1); PCSrcE must be ignored
        next_cyc();
        McStartE = 1; PCSrcE = 1;
        samp();
        chk("mc0_stalls", {StallF, StallD, StallE, FlushM}, 4'b1111);
        chk("mc0_busy_done", {McBusy, McDoneE}, 2'b00);
        chk("mc0_no_redirect", {FlushD, FlushE}, 2'b00);
        chk("mc1_done_now", u1_McDoneE, 1'b1);
        chk("mc1_no_stall", {u1_StallF, u1_StallE, u1_FlushD, u1_McBusy}, 4'b0000);
        next_cyc();
        McStartE = 0;
        samp();
        chk("mc1_state", {McBusy, McDoneE, StallE, FlushD}, 4'b1010);
        next_cyc();
        PCSrcE = 0;
        samp();
        chk("mc2_state", {McBusy, McDoneE, StallE}, 3'b101);
        next_cyc();
        samp();
        chk("mc3_done", {McBusy, McDoneE, StallE, StallF, FlushM}, 5'b11000);
        next_cyc();
        samp();
        chk("mc4_run", {McBusy, McDoneE, StallE}, 3'b000);
        chk("mc4_perf", PerfStallCnt, 4'd5);
        chk("mc1_perf", u1_PerfStallCnt, 4'd2);

        // memory wait inside MC_WAIT freezes the remaining count
        next_cyc();
        McStartE = 1;
        next_cyc();
        McStartE = 0;
        samp();
        chk("mw_busy", McBusy, 1'b1);
        for (int k = 0; k < 5; k++) begin
            next_cyc();
            MemReqM = 1; MemReadyM = 0;
            samp();
            chk($sformatf("mw%0d_stalls", k), {StallF, StallD, StallE, StallM, FlushW}, 5'b11111);
            chk($sformatf("mw%0d_other", k), {FlushD, FlushE, FlushM, McDoneE}, 4'b0000);
        end
        next_cyc();
        MemReadyM = 1;
        samp();
        chk("mw_resume", {McBusy, McDoneE, StallE, StallM, FlushW}, 5'b10100);
        next_cyc();
        idle();
        samp();
        chk("mw_done", {McBusy, McDoneE, StallE, MemErr}, 4'b1100);
        next_cyc();
        samp();
        chk("mw_run", {McBusy, StallF}, 2'b00);
        chk("mw_perf", PerfStallCnt, 4'd13);

        // memory timeout
        next_cyc();
        reset = 1;
        next_cyc();
        reset = 0;
        MemReqM = 1; MemReadyM = 0;
        for (int k = 1; k <= 8; k++) begin
            samp();
            if (k == 8) chk("to_before", MemErr, 1'b0);
            next_cyc();
        end
        samp();
        chk("to_set", {MemErr, StallF, StallM}, 3'b111);
        next_cyc();
        MemReadyM = 1;
        samp();
        chk("to_ready", {MemErr, StallF}, 2'b10);
        chk("to_perf", PerfStallCnt, 4'd9);
        next_cyc();
        idle();
        samp();
        chk("to_sticky", MemErr, 1'b1);
        next_cyc();
        reset = 1;
        next_cyc();
        reset = 0;
        samp();
        chk("to_cleared", {MemErr, StallF, McBusy}, 3'b000);
        chk("to_perf_clr", PerfStallCnt, 4'd0);

        // reset aborts multicycle and memory wait
        next_cyc();
        McStartE = 1;
        next_cyc();
        McStartE = 0;
        samp();
        chk("ab_mc_busy", McBusy, 1'b1);
        reset = 1;
        next_cyc();
        reset = 0;
        samp();
        chk("ab_mc_run", {McBusy, StallE, StallF}, 3'b000);
        next_cyc();
        MemReqM = 1;
        next_cyc();
        reset = 1; MemReqM = 0;
        next_cyc();
        reset = 0;
        samp();
        chk("ab_mem_run", {StallF, StallM, FlushW}, 3'b000);

        // saturation: 20 stalled cycles on a 4-bit counter
        next_cyc();
        MemReqM = 1;
        for (int k = 0; k < 20; k++) next_cyc();
        idle();
        samp();
        chk("sat_perf", PerfStallCnt, 4'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
